// File: rtl/mcore_pkg.sv
// Shared types and constants for the bitstream writer and its bit packer.
// Only 32-bit memory words are supported.
package mcore_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_REQ = 2'd1,
        WR_RSP = 2'd2
    } bw_state_t;

    localparam int         ACC_WIDTH  = 64;
    localparam int         WORD_BITS  = 32;
    localparam logic [3:0] MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/mcore_bitstream_writer_if.sv
// Memory initiator/target bundle: request channel out, grant and response back.
// Read data is present for protocol completeness only; the writer never reads.
interface mcore_bitstream_writer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic                    mem_gnt;
    logic                    mem_rsp_valid;
    logic                    mem_rsp_error;
    logic [DATA_WIDTH-1:0]   mem_rsp_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_gnt, mem_rsp_valid, mem_rsp_error, mem_rsp_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_gnt, mem_rsp_valid, mem_rsp_error, mem_rsp_rdata
    );
endinterface

// File: rtl/mcore_bit_packer.sv
// MSB-first bit accumulator: appends right-aligned fields below the fill point.
// Latency: state updates on the next edge; fill_nxt exposes the post-update fill.
module mcore_bit_packer
    import mcore_pkg::*;
(
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 clear,
    input  logic                 put_en,
    input  logic [31:0]          put_data,
    input  logic [5:0]           put_nbits,
    input  logic                 shift_en,
    output logic [ACC_WIDTH-1:0] acc_q,
    output logic [6:0]           fill_q,
    output logic [6:0]           fill_nxt
);

    logic [ACC_WIDTH-1:0] acc_d;
    logic [6:0]           fill_d;
    logic [ACC_WIDTH-1:0] field;
    logic [6:0]           shamt;

    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        field  = {32'd0, put_data} & ((ACC_WIDTH'(1) << put_nbits) - ACC_WIDTH'(1));
        // fill<32 and nbits<=32 whenever a put lands, so this never underflows
        shamt  = 7'd64 - fill_q - {1'b0, put_nbits};
        if (clear) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (shift_en) begin
            acc_d  = acc_q << WORD_BITS;
            fill_d = (fill_q >= 7'd32) ? (fill_q - 7'd32) : 7'd0;
        end else if (put_en) begin
            acc_d  = acc_q | (field << shamt);
            fill_d = fill_q + {1'b0, put_nbits};
        end
    end

    assign fill_nxt = fill_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/mcore_bitstream_writer.sv
// Packs variable-width fields into 32-bit words and writes them to sequential addresses.
// Latency: one cycle from a word-completing put to mem_req; put_ready is low while a word is in flight.
module mcore_bitstream_writer
    import mcore_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  attach_valid,
    input  logic [ADDR_WIDTH-1:0] attach_addr,
    input  logic                  put_valid,
    output logic                  put_ready,
    input  logic [31:0]           put_data,
    input  logic [5:0]            put_nbits,
    input  logic                  flush_valid,
    output logic                  busy,
    output logic                  error,
    mcore_bitstream_writer_if.master mem
);

    bw_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  err_q, err_d;
    logic                  pend_q, pend_d;

    logic [ACC_WIDTH-1:0]  acc_q;
    logic [6:0]            fill_q, fill_nxt;
    logic                  put_fire, put_en, attach_ok, shift_en;
    logic                  unused_bits;

    assign busy      = (state_q != IDLE) || pend_q;
    assign put_ready = aresetn && (state_q == IDLE) && (fill_q < 7'd32) && !pend_q && !attach_valid;
    assign put_fire  = put_valid && put_ready;
    assign put_en    = put_fire && (put_nbits != 6'd0) && (put_nbits <= 6'd32);
    assign attach_ok = attach_valid && !busy;
    assign error     = err_q;

    mcore_bit_packer u_packer (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .clear     (attach_ok),
        .put_en    (put_en),
        .put_data  (put_data),
        .put_nbits (put_nbits),
        .shift_en  (shift_en),
        .acc_q     (acc_q),
        .fill_q    (fill_q),
        .fill_nxt  (fill_nxt)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        err_d    = err_q;
        pend_d   = pend_q || flush_valid;
        shift_en = 1'b0;
        if (put_fire && (put_nbits > 6'd32)) err_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (attach_ok) begin
                    ptr_d = {attach_addr[ADDR_WIDTH-1:2], 2'b00};
                    err_d = 1'b0;
                end else if ((fill_nxt >= 7'd32) || ((pend_q || flush_valid) && (fill_nxt != 7'd0))) begin
                    state_d = WR_REQ;
                end else if (pend_q) begin
                    // flush drained: nothing left below the fill point
                    pend_d = flush_valid;
                end
            end
            WR_REQ: if (mem.mem_gnt) state_d = WR_RSP;
            WR_RSP: begin
                if (mem.mem_rsp_valid) begin
                    state_d  = IDLE;
                    shift_en = 1'b1;
                    ptr_d    = ptr_q + ADDR_WIDTH'(4);
                    if (mem.mem_rsp_error) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    // Request fields derive straight from held state, so they stay put until grant.
    assign mem.mem_req   = (state_q == WR_REQ);
    assign mem.mem_we    = (state_q == WR_REQ);
    assign mem.mem_be    = (state_q == WR_REQ) ? MEM_BE_ALL : '0;
    assign mem.mem_addr  = ptr_q;
    assign mem.mem_wdata = acc_q[ACC_WIDTH-1 -: DATA_WIDTH];

    assign unused_bits = ^{mem.mem_rsp_rdata, attach_addr[1:0]};

endmodule
